// File: rtl/shiftadd_pkg.sv
// -----------------------------------------------------------------------------
// shiftadd_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - state_e : FSM state encoding (IDLE / CALC / DONE)
//   - prod_w  : product width helper (2 * operand width)
//   - cnt_w   : iteration counter width helper (clog2(width + 1))
// -----------------------------------------------------------------------------
package shiftadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Product width for a given operand width.
  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // Counter width able to hold the values 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shiftadd_multiplier_adder.sv
// -----------------------------------------------------------------------------
// shiftadd_multiplier_adder
// Sum-only ripple-carry adder used as the multiplier accumulator.
// Carry-in is tied to 0 and the carry-out is not produced: the multiplier
// never overflows its 2*WIDTH accumulator, so the top carry is always 0.
// Ports:
//   a_i   [W-1:0]  first addend (accumulator)
//   b_i   [W-1:0]  second addend (gated, shifted multiplicand)
//   sum_o [W-1:0]  a_i + b_i, modulo 2^W
// -----------------------------------------------------------------------------
module shiftadd_multiplier_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  // carry_s[i] is the carry into bit i; carry_s[0] is the tied-off carry-in.
  logic [W-1:0] carry_s;

  assign carry_s[0] = 1'b0;

  // One full-adder cell per bit.
  for (genvar i = 0; i < W; i++) begin : g_sum
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s[i];
  end

  // Carry chain; the carry out of the top bit is intentionally not built.
  for (genvar i = 0; i < W - 1; i++) begin : g_carry
    assign carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
  end

endmodule

// File: rtl/shiftadd_multiplier.sv
// -----------------------------------------------------------------------------
// shiftadd_multiplier
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One conditional add per cycle; start/busy/done handshake.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   start    request a multiply (accepted in IDLE or DONE)
//   input1   [WIDTH-1:0]   multiplicand, unsigned
//   input2   [WIDTH-1:0]   multiplier, unsigned
//   busy     high while a multiply is in progress
//   done     one-cycle pulse when product becomes valid
//   product  [2*WIDTH-1:0] result, held until the next result is produced
// Build option:
//   SHIFTADD_EARLY_TERMINATE_EN - finish as soon as the remaining multiplier
//   bits are all zero instead of always running WIDTH add cycles.
// -----------------------------------------------------------------------------
module shiftadd_multiplier
  import shiftadd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WIDTH-1:0]            input1,
  input  logic [WIDTH-1:0]            input2,
  output logic                        busy,
  output logic                        done,
  output logic [prod_w(WIDTH)-1:0]    product
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  state_e          state_q,   state_d;
  logic [PW-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q,     acc_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic [PW-1:0]   product_q, product_d;

  logic [PW-1:0]   addend_s;
  logic [PW-1:0]   sum_s;
  logic            last_s;

  // Only add the multiplicand when the current multiplier LSB is set.
  assign addend_s = mplier_q[0] ? mcand_q : {PW{1'b0}};

  shiftadd_multiplier_adder #(
    .W (PW)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (addend_s),
    .sum_o (sum_s)
  );

`ifdef SHIFTADD_EARLY_TERMINATE_EN
  // Stop once no set multiplier bits remain after this cycle's add.
  assign last_s = (cnt_q == CW'(WIDTH - 1)) ||
                  (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
  // Always run the full WIDTH add cycles.
  assign last_s = (cnt_q == CW'(WIDTH - 1));
`endif

  // Next-state logic: FSM, shift registers, counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE.
        if (start) begin
          mcand_d  = {{(PW-WIDTH){1'b0}}, input1};
          mplier_d = input2;
          acc_d    = {PW{1'b0}};
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b1;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        acc_d    = sum_s;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (last_s) begin
          // Capture the final sum straight from the adder on entry to DONE.
          product_d = sum_s;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end else begin
          busy_d    = 1'b1;
          state_d   = CALC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= {PW{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {PW{1'b0}};
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shiftadd_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shiftadd_multiplier
// Self-checking bench: a cycle-level behavioural model of the handshake and
// product (plain multiply + countdown) is compared against the DUT on every
// falling edge, plus directed operations with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_shiftadd_multiplier;

`ifdef SHIFTADD_EARLY_TERMINATE_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  input1;
  logic [7:0]  input2;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_pass  = 0;
  int n_total = 0;

  shiftadd_multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .input1  (input1),
    .input2  (input2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Number of add cycles an operation spends busy.
  function automatic int ncalc(input logic [7:0] b);
    int k;
    if (!ET) return 8;
    k = 1;
    for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_left   = 0;
  logic        m_done   = 1'b0;
  logic [15:0] m_prod   = 16'd0;
  logic [15:0] m_pend   = 16'd0;
  bit          m_valid  = 1'b0;
  int          accepted = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_prod  <= 16'd0;
      m_valid <= 1'b1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_prod <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left   <= ncalc(input2);
        m_pend   <= 16'(input1) * 16'(input2);
        accepted <= accepted + 1;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("product", 32'(product), 32'(m_prod));
    end
  end

  // One directed multiply with literal latency/product expectations.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input int exp_n, input bit poke);
    int n;
    bit got;
    input1 = a;
    input2 = b;
    start  = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (poke && n == 3) begin
        start  = 1'b1;
        input1 = 8'($urandom);
        input2 = 8'($urandom);
      end
      if (poke && n == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("op_latency", 32'(n), 32'(exp_n));
    check("op_product", 32'(product), 32'(exp_p));
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  initial begin
    int target;
    reset  = 1'b1;
    start  = 1'b0;
    input1 = 8'd0;
    input2 = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic with an ignored mid-CALC start, then back-to-back from DONE.
    run_op(8'd13, 8'd11, 16'd143, ET ? 5 : 9, 1'b1);
    run_op(8'd3, 8'd5, 16'd15, ET ? 4 : 9, 1'b0);
    @(negedge clk);
    run_op(8'hFF, 8'hFF, 16'hFE01, 9, 1'b0);
    @(negedge clk);
    run_op(8'd0, 8'd200, 16'd0, 9, 1'b0);
    @(negedge clk);
    run_op(8'd57, 8'd1, 16'd57, ET ? 2 : 9, 1'b0);
    @(negedge clk);

    // Reset during CALC: no done pulse, everything cleared.
    input1 = 8'd100;
    input2 = 8'd100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_product", 32'(product), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op(8'd2, 8'd2, 16'd4, ET ? 3 : 9, 1'b0);
    @(negedge clk);

    // Randomized sweep: random starts (some while busy / in DONE), rare resets.
    target = accepted + 1000;
    for (int c = 0; c < 40000 && accepted < target; c++) begin
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      input1 = pick();
      input2 = pick();
      reset  = ($urandom_range(0, 511) == 0);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("sweep_accepted", 32'(accepted >= target), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
